// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and small decode helpers for the memory slave.
package ahb_pkg;

    // Transfer type carried on htrans
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    // Transfer size carried on hsize (only the three legal sizes are named)
    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    // Slave response carried on hresp
    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    // Slave FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Byte lanes touched by a transfer of the given size at the given low address bits
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << lo;
            HSIZE_HALF: mask = lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // True when a legal size is not naturally aligned
    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
        return ((size == HSIZE_HALF) && lo[0]) ||
               ((size == HSIZE_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite slave-side bus bundle: master mux / decoder inputs and slave responses.
interface ahb_mem_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sp_ram.sv
// Single-port DEPTH x 32 memory, one byte-wide array per lane, byte-enable write, async read.
module ahb_sp_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            // Lane write: only when this lane is enabled; no reset, contents persist
            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = mem[addr];
        end
    endgenerate

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: programmable wait states, byte-lane writes, two-cycle ERROR.
import ahb_pkg::*;

module ahb_mem_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic       hclk,
    input  logic       hreset,
    ahb_mem_slave_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;

    logic        accept;
    logic        acc_err;
    logic        complete;
    logic        take;

    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;

    // Address-phase qualification and the error check on the live bus
    always_comb begin
        accept   = bus.hsel && bus.hready && bus.htrans[1];
        acc_err  = (bus.haddr[31:2] >= 30'(DEPTH)) ||
                   (bus.hsize > 3'(HSIZE_WORD)) ||
                   misaligned(bus.hsize, bus.haddr[1:0]);
        complete = (state_q == ST_DATA) && (cnt_q == 4'd0);
    end

    // Next-state, wait counter, captured address phase and registered responses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        take    = 1'b0;

        case (state_q)
            ST_IDLE: take = accept;
            ST_DATA: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                    take    = accept;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            // A transfer offered during the second error cycle is dropped on purpose
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            addr_d  = bus.haddr;
            write_d = bus.hwrite;
            size_d  = bus.hsize;
            if (acc_err) begin
                state_d = ST_ERR1;
            end else begin
                state_d = ST_DATA;
                cnt_d   = 4'(WAIT_STATES);
            end
        end

        // Outputs are precomputed from the next state so they come straight off flops
        hreadyout_d = !((state_d == ST_ERR1) || ((state_d == ST_DATA) && (cnt_d != 4'd0)));
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // State register with synchronous reset; memory is not touched by reset
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 32'd0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Write fires in the completing cycle; a reset in that cycle cancels it
    always_comb begin
        ram_we = complete && write_q && !hreset;
        ram_be = lane_mask(size_q, addr_q[1:0]);
    end

    ahb_sp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (hclk),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (addr_q[AW+1:2]),
        .wdata (bus.hwdata),
        .rdata (ram_rdata)
    );

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = (complete && !write_q) ? ram_rdata : 32'd0;

    // Burst, protection, lock, SEQ-vs-NONSEQ and high address bits carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0], addr_q[31:AW+2]};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Self-checking bench: WAIT_STATES=1 instance for most scenarios, WAIT_STATES=0 for pipelining.
module tb_ahb_mem_slave;
    import ahb_pkg::*;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_mem_slave_if bus1();
    ahb_mem_slave_if bus0();

    ahb_mem_slave #(.DEPTH(64), .WAIT_STATES(1)) dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1));
    ahb_mem_slave #(.DEPTH(64), .WAIT_STATES(0)) dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        resp;
        int          lows;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
    } stim_t;

    exp_t        sb[$];
    logic [31:0] rq[$];
    logic [31:0] model [64];

    // Reference behaviour for one transfer on the WAIT_STATES=1 slave
    function automatic exp_t model_xfer(input logic wr, input logic [31:0] a,
                                        input logic [2:0] sz, input logic [31:0] wd);
        exp_t e;
        logic err;
        int   idx;
        err = (a[31:2] >= 30'd64) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
              (sz == 3'd2 && a[1:0] != 2'd0);
        e.lows = 1;
        e.resp = err;
        e.data = 32'd0;
        if (!err) begin
            idx = int'(a[7:2]);
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (sz == 3'd2 || (sz == 3'd1 && (b / 2) == int'(a[1])) ||
                        (sz == 3'd0 && b == int'(a[1:0])))
                        model[idx][b*8 +: 8] = wd[b*8 +: 8];
                end
            end else begin
                e.data = model[idx];
            end
        end
        return e;
    endfunction

    task automatic idle_bus();
        bus1.hsel = 0; bus1.htrans = 2'd0; bus1.haddr = 0; bus1.hwrite = 0; bus1.hsize = 3'd2;
        bus1.hburst = 0; bus1.hprot = 0; bus1.hmastlock = 0; bus1.hready = 1; bus1.hwdata = 0;
        bus0.hsel = 0; bus0.htrans = 2'd0; bus0.haddr = 0; bus0.hwrite = 0; bus0.hsize = 3'd2;
        bus0.hburst = 0; bus0.hprot = 0; bus0.hmastlock = 0; bus0.hready = 1; bus0.hwdata = 0;
    endtask

    // Drive one NONSEQ transfer on bus1 and record what the slave returned
    task automatic issue1(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, output int lows, output logic rf,
                          output logic rl, output logic [31:0] rd, output logic to);
        lows = 0; rf = 0; rl = 0; rd = 0; to = 1;
        bus1.hsel = 1; bus1.htrans = 2'd2; bus1.haddr = a; bus1.hwrite = wr; bus1.hsize = sz;
        bus1.hready = 1;
        @(posedge hclk); #1;
        bus1.hsel = 0; bus1.htrans = 2'd0; bus1.hwdata = wd;
        for (int c = 0; c < 20; c++) begin
            @(negedge hclk);
            if (c == 0) rf = bus1.hresp;
            if (bus1.hreadyout) begin
                rl = bus1.hresp; rd = bus1.hrdata; to = 0;
                break;
            end
            lows++;
            @(posedge hclk); #1;
        end
        @(posedge hclk); #1;
        $display("xfer wr=%0b addr=%08h size=%0d wdata=%08h lows=%0d resp=%0b/%0b rdata=%08h",
                 wr, a, sz, wd, lows, rf, rl, rd);
    endtask

    task automatic test_reset();
        idle_bus();
        hreset = 1;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        checks++; if (bus1.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout1 got=%0b want=1", bus1.hreadyout); end
        checks++; if (bus1.hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp1 got=%0b want=0", bus1.hresp); end
        checks++; if (bus1.hrdata !== 32'd0) begin errors++; $display("FAIL reset_hrdata1 got=%08h want=0", bus1.hrdata); end
        checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout0 got=%0b want=1", bus0.hreadyout); end
        checks++; if (bus0.hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp0 got=%0b want=0", bus0.hresp); end
        @(posedge hclk); #1;
        hreset = 0;
        $display("reset released");
    endtask

    task automatic test_word_rw();
        stim_t t[2];
        int lows; logic rf, rl, to; logic [31:0] rd; exp_t e;
        t[0] = '{1'b1, 32'h10, 3'd2, 32'hDEADBEEF};
        t[1] = '{1'b0, 32'h10, 3'd2, 32'h0};
        foreach (t[i]) begin
            sb.push_back(model_xfer(t[i].wr, t[i].a, t[i].sz, t[i].wd));
            issue1(t[i].wr, t[i].a, t[i].sz, t[i].wd, lows, rf, rl, rd, to);
            e = sb.pop_front();
            checks++; if (to) begin errors++; $display("FAIL word_rw[%0d] timeout", i); end
            checks++; if (lows !== e.lows) begin errors++; $display("FAIL word_rw[%0d] lows got=%0d want=%0d", i, lows, e.lows); end
            checks++; if (rf !== e.resp || rl !== e.resp) begin errors++; $display("FAIL word_rw[%0d] hresp got=%0b/%0b want=%0b", i, rf, rl, e.resp); end
            checks++; if (rd !== e.data) begin errors++; $display("FAIL word_rw[%0d] hrdata got=%08h want=%08h", i, rd, e.data); end
        end
    endtask

    task automatic test_byte_write();
        stim_t t[4];
        int lows; logic rf, rl, to; logic [31:0] rd; exp_t e;
        t[0] = '{1'b1, 32'h11, 3'd0, 32'h0000AA00};
        t[1] = '{1'b0, 32'h10, 3'd2, 32'h0};
        t[2] = '{1'b1, 32'h12, 3'd1, 32'h1234CCCC};
        t[3] = '{1'b0, 32'h10, 3'd2, 32'h0};
        foreach (t[i]) begin
            sb.push_back(model_xfer(t[i].wr, t[i].a, t[i].sz, t[i].wd));
            issue1(t[i].wr, t[i].a, t[i].sz, t[i].wd, lows, rf, rl, rd, to);
            e = sb.pop_front();
            checks++; if (to) begin errors++; $display("FAIL byte_wr[%0d] timeout", i); end
            checks++; if (rf !== e.resp || rl !== e.resp) begin errors++; $display("FAIL byte_wr[%0d] hresp got=%0b/%0b want=%0b", i, rf, rl, e.resp); end
            checks++; if (rd !== e.data) begin errors++; $display("FAIL byte_wr[%0d] hrdata got=%08h want=%08h", i, rd, e.data); end
        end
    endtask

    task automatic test_errors();
        stim_t t[10];
        int lows; logic rf, rl, to; logic [31:0] rd; exp_t e;
        t[0] = '{1'b0, 32'h100,       3'd2, 32'h0};
        t[1] = '{1'b0, 32'h10,        3'd2, 32'h0};
        t[2] = '{1'b1, 32'h13,        3'd1, 32'hFFFFFFFF};
        t[3] = '{1'b0, 32'h10,        3'd2, 32'h0};
        t[4] = '{1'b1, 32'h10,        3'd3, 32'h0BADF00D};
        t[5] = '{1'b1, 32'h12,        3'd2, 32'h0BADF00D};
        t[6] = '{1'b1, 32'h40000010,  3'd2, 32'h0BADF00D};
        t[7] = '{1'b1, 32'hFC,        3'd2, 32'hA5A55A5A};
        t[8] = '{1'b0, 32'hFC,        3'd2, 32'h0};
        t[9] = '{1'b0, 32'h10,        3'd2, 32'h0};
        foreach (t[i]) begin
            sb.push_back(model_xfer(t[i].wr, t[i].a, t[i].sz, t[i].wd));
            issue1(t[i].wr, t[i].a, t[i].sz, t[i].wd, lows, rf, rl, rd, to);
            e = sb.pop_front();
            checks++; if (to) begin errors++; $display("FAIL err[%0d] timeout", i); end
            checks++; if (lows !== e.lows) begin errors++; $display("FAIL err[%0d] lows got=%0d want=%0d", i, lows, e.lows); end
            checks++; if (rf !== e.resp || rl !== e.resp) begin errors++; $display("FAIL err[%0d] hresp got=%0b/%0b want=%0b", i, rf, rl, e.resp); end
            checks++; if (rd !== e.data) begin errors++; $display("FAIL err[%0d] hrdata got=%08h want=%08h", i, rd, e.data); end
        end
    endtask

    task automatic test_ignored();
        logic [1:0] tr[4];
        logic       sel[4];
        logic       rdy[4];
        int lows; logic rf, rl, to; logic [31:0] rd; exp_t e;
        tr[0] = 2'd2; sel[0] = 0; rdy[0] = 1;
        tr[1] = 2'd0; sel[1] = 1; rdy[1] = 1;
        tr[2] = 2'd1; sel[2] = 1; rdy[2] = 1;
        tr[3] = 2'd2; sel[3] = 1; rdy[3] = 0;
        for (int i = 0; i < 4; i++) begin
            bus1.hsel = sel[i]; bus1.htrans = tr[i]; bus1.hready = rdy[i];
            bus1.haddr = 32'h10; bus1.hwrite = 1; bus1.hsize = 3'd2;
            @(posedge hclk); #1;
            bus1.hsel = 0; bus1.htrans = 2'd0; bus1.hready = 1; bus1.hwdata = 32'hFFFFFFFF;
            @(negedge hclk);
            $display("ignored sel=%0b htrans=%0d hready=%0b -> hreadyout=%0b hresp=%0b", sel[i], tr[i], rdy[i], bus1.hreadyout, bus1.hresp);
            checks++; if (bus1.hreadyout !== 1'b1) begin errors++; $display("FAIL ignored[%0d] hreadyout got=%0b want=1", i, bus1.hreadyout); end
            checks++; if (bus1.hresp !== 1'b0) begin errors++; $display("FAIL ignored[%0d] hresp got=%0b want=0", i, bus1.hresp); end
            @(posedge hclk); #1;
            bus1.hwdata = 32'd0;
        end
        sb.push_back(model_xfer(1'b0, 32'h10, 3'd2, 32'h0));
        issue1(1'b0, 32'h10, 3'd2, 32'h0, lows, rf, rl, rd, to);
        e = sb.pop_front();
        checks++; if (to || rd !== e.data) begin errors++; $display("FAIL ignored_readback got=%08h want=%08h to=%0b", rd, e.data, to); end
    endtask

    task automatic test_reset_mid_write();
        int lows; logic rf, rl, to; logic [31:0] rd; exp_t e;
        sb.push_back(model_xfer(1'b1, 32'h8, 3'd2, 32'h12345678));
        issue1(1'b1, 32'h8, 3'd2, 32'h12345678, lows, rf, rl, rd, to);
        e = sb.pop_front();
        checks++; if (to || rf !== e.resp) begin errors++; $display("FAIL rst_pre_write resp got=%0b want=%0b to=%0b", rf, e.resp, to); end
        // Start a write that reset will abandon; the model is deliberately not updated
        bus1.hsel = 1; bus1.htrans = 2'd2; bus1.haddr = 32'h8; bus1.hwrite = 1; bus1.hsize = 3'd2;
        @(posedge hclk); #1;
        bus1.hsel = 0; bus1.htrans = 2'd0; bus1.hwdata = 32'h55555555;
        @(negedge hclk);
        checks++; if (bus1.hreadyout !== 1'b0) begin errors++; $display("FAIL rst_wait hreadyout got=%0b want=0", bus1.hreadyout); end
        hreset = 1;
        @(posedge hclk); #1;
        hreset = 0;
        @(negedge hclk);
        $display("reset mid-write -> hreadyout=%0b hresp=%0b", bus1.hreadyout, bus1.hresp);
        checks++; if (bus1.hreadyout !== 1'b1) begin errors++; $display("FAIL rst_mid hreadyout got=%0b want=1", bus1.hreadyout); end
        checks++; if (bus1.hresp !== 1'b0) begin errors++; $display("FAIL rst_mid hresp got=%0b want=0", bus1.hresp); end
        @(posedge hclk); #1;
        bus1.hwdata = 32'd0;
        sb.push_back(model_xfer(1'b0, 32'h8, 3'd2, 32'h0));
        issue1(1'b0, 32'h8, 3'd2, 32'h0, lows, rf, rl, rd, to);
        e = sb.pop_front();
        checks++; if (to || rd !== e.data) begin errors++; $display("FAIL rst_readback got=%08h want=%08h to=%0b", rd, e.data, to); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd;
        bus0.hsel = 1; bus0.htrans = 2'd2; bus0.hwrite = 1; bus0.haddr = 32'h0; bus0.hsize = 3'd2;
        @(posedge hclk); #1;
        bus0.hwdata = 32'h11111111; bus0.haddr = 32'h4;
        @(negedge hclk);
        $display("b2b write 0x0 data phase hreadyout=%0b", bus0.hreadyout);
        checks++; if (bus0.hreadyout !== 1'b1 || bus0.hresp !== 1'b0) begin errors++; $display("FAIL b2b_c1 ready/resp got=%0b/%0b want=1/0", bus0.hreadyout, bus0.hresp); end
        @(posedge hclk); #1;
        bus0.hwdata = 32'h22222222; bus0.hwrite = 0; bus0.haddr = 32'h0; rq.push_back(32'h11111111);
        @(negedge hclk);
        $display("b2b write 0x4 data phase hreadyout=%0b", bus0.hreadyout);
        checks++; if (bus0.hreadyout !== 1'b1 || bus0.hresp !== 1'b0) begin errors++; $display("FAIL b2b_c2 ready/resp got=%0b/%0b want=1/0", bus0.hreadyout, bus0.hresp); end
        @(posedge hclk); #1;
        bus0.haddr = 32'h4; rq.push_back(32'h22222222);
        @(negedge hclk);
        exp_rd = rq.pop_front();
        $display("b2b read 0x0 hrdata=%08h hreadyout=%0b", bus0.hrdata, bus0.hreadyout);
        checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("FAIL b2b_c3 hreadyout got=%0b want=1", bus0.hreadyout); end
        checks++; if (bus0.hrdata !== exp_rd) begin errors++; $display("FAIL b2b_rd0 hrdata got=%08h want=%08h", bus0.hrdata, exp_rd); end
        @(posedge hclk); #1;
        bus0.haddr = 32'h100;
        @(negedge hclk);
        exp_rd = rq.pop_front();
        $display("b2b read 0x4 hrdata=%08h hreadyout=%0b", bus0.hrdata, bus0.hreadyout);
        checks++; if (bus0.hreadyout !== 1'b1) begin errors++; $display("FAIL b2b_c4 hreadyout got=%0b want=1", bus0.hreadyout); end
        checks++; if (bus0.hrdata !== exp_rd) begin errors++; $display("FAIL b2b_rd4 hrdata got=%08h want=%08h", bus0.hrdata, exp_rd); end
        @(posedge hclk); #1;
        bus0.hsel = 0; bus0.htrans = 2'd0;
        @(negedge hclk);
        $display("ws0 error cycle1 hreadyout=%0b hresp=%0b", bus0.hreadyout, bus0.hresp);
        checks++; if (bus0.hreadyout !== 1'b0 || bus0.hresp !== 1'b1) begin errors++; $display("FAIL ws0_err1 ready/resp got=%0b/%0b want=0/1", bus0.hreadyout, bus0.hresp); end
        @(posedge hclk); #1;
        @(negedge hclk);
        $display("ws0 error cycle2 hreadyout=%0b hresp=%0b", bus0.hreadyout, bus0.hresp);
        checks++; if (bus0.hreadyout !== 1'b1 || bus0.hresp !== 1'b1 || bus0.hrdata !== 32'd0) begin errors++; $display("FAIL ws0_err2 ready/resp/rdata got=%0b/%0b/%08h want=1/1/0", bus0.hreadyout, bus0.hresp, bus0.hrdata); end
        @(posedge hclk); #1;
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_write();
        test_errors();
        test_ignored();
        test_reset_mid_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
